signed_accumulator: RTL and testbench
=====================================

SIGNED_ACCUMULATOR -- requirements
Module: signed_accumulator

Interface
REQ-001 Parameter ACC_W, default 12: accumulator/output width in bits, 8..32.
REQ-002 Parameter N_SAMPLES, default 4: accepted samples per frame, 1..255.
REQ-003 Clocking and reset SHALL be one clock, with a synchronous, active-low reset.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 in_data  input  8  signed two's-complement sample (8-bit sign-extended sum from the upstream signed adder).
REQ-007 in_valid  input  1  in_data valid this cycle.
REQ-008 in_ready  output  1  block can accept a sample this cycle.
REQ-009 clear  input  1  synchronous abort/clear of current frame.
REQ-010 out_data  output  ACC_W  signed frame result.
REQ-011 out_ovf  output  1  frame overflowed ACC_W signed range.
REQ-012 out_valid  output  1  frame result valid.
REQ-013 out_ready  input  1  downstream accepts the result.

Function
REQ-014 The block SHALL use FSM states IDLE, ACC, HOLD.
REQ-015 A sample SHALL be accepted on a cycle when in_valid=1 and in_ready=1.
REQ-016 in_ready SHALL be 1 in IDLE and ACC, and 0 in HOLD.
REQ-017 On an accept in IDLE: acc <= sext(in_data), cnt <= 1, ovf <= 0, next state ACC (HOLD if N_SAMPLES=1).
REQ-018 On an accept in ACC: acc <= acc + sext(in_data), cnt <= cnt+1, next state HOLD when cnt+1 = N_SAMPLES, else stay in ACC.
REQ-019 ACC with no accept SHALL hold all state (arbitrary in_valid gaps allowed).
REQ-020 HOLD: out_valid=1, out_data=acc, out_ovf=ovf; all SHALL stay stable until out_ready=1, then go to IDLE on the next edge.
REQ-021 Latency: out_valid SHALL rise on the cycle after the edge that accepts the N_SAMPLES-th sample.
REQ-022 out_valid SHALL be 0 in IDLE and ACC.
REQ-023 out_data and out_ovf SHALL be 0 outside HOLD.
REQ-024 Overflow: ovf SHALL be set sticky for the frame when the exact (ACC_W+1)-bit sum of any accept falls outside [-2^(ACC_W-1), 2^(ACC_W-1)-1].
REQ-025 clear=1 SHALL force IDLE, acc=0, cnt=0, ovf=0 from any state; it takes priority over a simultaneous accept or out_ready, and no sample is taken that cycle.
REQ-026 cnt SHALL never exceed N_SAMPLES and SHALL NOT wrap.

Reset
REQ-027 While rst_n=0 at a clock edge, the block SHALL load state IDLE, acc=0, cnt=0, ovf=0.
REQ-028 During and after reset the outputs SHALL be in_ready=1, out_valid=0, out_data=0, out_ovf=0.
REQ-029 Reset mid-frame or in HOLD SHALL discard the frame, with no out_valid for it.
REQ-030 Reset SHALL take priority over clear.

Configuration
REQ-031 Macro ACC_SATURATE_EN: when defined, an overflowing add SHALL clamp acc to 2^(ACC_W-1)-1 (positive overflow) or -2^(ACC_W-1) (negative overflow).
REQ-032 When ACC_SATURATE_EN is undefined, acc SHALL wrap modulo 2^ACC_W.
REQ-033 out_ovf behaviour SHALL be identical in both builds.

Structure
REQ-034 Shared package alu_pkg SHALL hold the FSM state encodings (IDLE=2'd0, ACC=2'd1, HOLD=2'd2) and the default ACC_W and N_SAMPLES constants.
REQ-035 One combinational sub-module, acc_adder, SHALL provide the ACC_W-bit signed add with overflow detect and optional clamp.
REQ-036 The FSM, counter and registers SHALL reside in signed_accumulator.

Verification
REQ-037 ACC_W=12, N=4, samples 0x07, 0xF8, 0x05, 0xFF back-to-back -> out_valid one cycle after 4th accept, out_data=0x003, out_ovf=0.
REQ-038 ACC_W=8, N=4, samples 100, 100, -50, -50, ACC_SATURATE_EN defined -> out_data=27, out_ovf=1; macro undefined -> out_data=100, out_ovf=1.
REQ-039 Backpressure: result ready, out_ready=0 for 3 cycles -> out_valid=1, out_data stable, in_ready=0 throughout; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-040 clear asserted with in_valid=1 after 2 accepts -> sample not taken, next frame of 4 samples of 1 gives out_data=4.
REQ-041 rst_n=0 for one cycle in HOLD -> out_valid=0 next cycle, out_data=0, in_ready=1; next frame correct.
REQ-042 N=1 with sample 0x80 -> out_data=-128 sign-extended (0xF80 at ACC_W=12), out_valid on following cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the signed accumulator: default geometry and FSM state codes.
package alu_pkg;

  localparam int unsigned DefAccW     = 12;
  localparam int unsigned DefNSamples = 4;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAcc  = 2'd1;
  localparam logic [1:0] StHold = 2'd2;

endpackage

// File: rtl/acc_adder.sv
// Combinational ACC_W-bit signed add of an 8-bit signed sample, with overflow detect.
// Build option ACC_SATURATE_EN: clamp the sum to the signed range on overflow instead of wrapping.
module acc_adder
  import alu_pkg::*;
#(
  parameter int unsigned ACC_W = DefAccW
) (
  input  logic [ACC_W-1:0] a,
  input  logic [7:0]       b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  // One guard bit holds the exact result of any single add.
  logic [ACC_W:0] exact;

  assign exact = {a[ACC_W-1], a} + {{(ACC_W - 7){b[7]}}, b};
  assign ovf   = exact[ACC_W] ^ exact[ACC_W-1];

  // Select wrapped or clamped result; the guard bit gives the overflow direction.
  always_comb begin
    sum = exact[ACC_W-1:0];
`ifdef ACC_SATURATE_EN
    if (ovf) begin
      sum = exact[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}} : {1'b0, {(ACC_W - 1){1'b1}}};
    end
`else
`endif
  end

endmodule

// File: rtl/signed_accumulator.sv
// Frame accumulator: sums N_SAMPLES signed 8-bit samples, then holds the result until taken.
// Build option ACC_SATURATE_EN (in acc_adder) selects saturating instead of wrapping sums.
module signed_accumulator
  import alu_pkg::*;
#(
  parameter int unsigned ACC_W     = DefAccW,
  parameter int unsigned N_SAMPLES = DefNSamples
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clear,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [7:0] NLast = 8'(N_SAMPLES);

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic [ACC_W-1:0] add_a;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;

  assign in_ready = (state_q != StHold);
  assign accept   = in_valid & in_ready;

  // First sample of a frame adds onto zero, which is a plain sign extension.
  assign add_a = (state_q == StIdle) ? '0 : acc_q;

  acc_adder #(
    .ACC_W(ACC_W)
  ) u_adder (
    .a  (add_a),
    .b  (in_data),
    .sum(add_sum),
    .ovf(add_ovf)
  );

  // Next-state logic; clear overrides any accept or result handshake.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clear) begin
      state_d = StIdle;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            acc_d   = add_sum;
            cnt_d   = 8'd1;
            ovf_d   = 1'b0;
            state_d = (NLast == 8'd1) ? StHold : StAcc;
          end
        end
        StAcc: begin
          if (accept) begin
            acc_d = add_sum;
            cnt_d = cnt_q + 8'd1;
            ovf_d = ovf_q | add_ovf;
            if (cnt_q + 8'd1 == NLast) begin
              state_d = StHold;
            end
          end
        end
        StHold: begin
          if (out_ready) begin
            state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = (state_q == StHold);
  assign out_data  = out_valid ? acc_q : '0;
  assign out_ovf   = out_valid & ovf_q;

endmodule

// File: tb/tb_signed_accumulator.sv
// Scoreboard bench: main DUT at ACC_W=8, N=4 (so overflow is reachable) plus an N=1 instance.
module tb_signed_accumulator;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int W1 = 12;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   in_data = '0;
  logic         in_valid = 1'b0;
  logic         clear = 1'b0;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_ovf;
  logic         out_valid;
  logic         out_ready = 1'b1;

  logic [7:0]    in_data1 = '0;
  logic          in_valid1 = 1'b0;
  logic          in_ready1;
  logic [W1-1:0] out_data1;
  logic          out_ovf1;
  logic          out_valid1;
  logic          out_ready1 = 1'b0;

  signed_accumulator #(.ACC_W(W), .N_SAMPLES(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .clear    (clear),
    .out_data (out_data),
    .out_ovf  (out_ovf),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  signed_accumulator #(.ACC_W(W1), .N_SAMPLES(1)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data1),
    .in_valid (in_valid1),
    .in_ready (in_ready1),
    .clear    (1'b0),
    .out_data (out_data1),
    .out_ovf  (out_ovf1),
    .out_valid(out_valid1),
    .out_ready(out_ready1)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [W-1:0] data;
    bit           ovf;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  bit   rand_ready = 1'b0;

  // Reference: walk the frame with integer arithmetic, applying the range rule per add.
  function automatic void model(input logic [7:0] s[N], output logic [W-1:0] res, output bit ovf);
    int lo;
    int hi;
    int a;
    lo  = -(1 << (W - 1));
    hi  = (1 << (W - 1)) - 1;
    a   = 0;
    ovf = 1'b0;
    for (int i = 0; i < N; i++) begin
      a = a + int'($signed(s[i]));
      if (a > hi || a < lo) begin
        ovf = 1'b1;
`ifdef ACC_SATURATE_EN
        a = (a > hi) ? hi : lo;
`else
        a = (a > hi) ? a - (1 << W) : a + (1 << W);
`endif
      end
    end
    res = a[W-1:0];
  endfunction

  // Random downstream readiness while enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: every completed result handshake must match the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got %0h with no frame expected", out_data);
      end else begin
        e = sb.pop_front();
        check("frame_data", 32'(out_data), 32'(e.data));
        check("frame_ovf", 32'(out_ovf), 32'(e.ovf));
      end
    end
  end

  // Offer one sample, returning just after the edge that accepts it.
  task automatic send(input logic [7:0] d);
    int guard;
    guard    = 0;
    in_data  = d;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      guard++;
      if (guard > 100) begin
        n_cmp++;
        n_bad++;
        $display("FAIL send_timeout: in_ready stayed 0, expected 1");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] s[N], input bit push, input bit gaps);
    exp_t e;
    model(s, e.data, e.ovf);
    last_exp = e;
    if (push) sb.push_back(e);
    for (int i = 0; i < N; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      send(s[i]);
    end
    @(negedge clk);
    check("latency_valid", 32'(out_valid), 32'd1);
  endtask

  logic [7:0] smp[N];
  int         guard;

  initial begin
    // Reset behaviour
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;

    // Back-to-back small frame
    smp = '{8'h07, 8'hF8, 8'h05, 8'hFF};
    run_frame(smp, 1'b1, 1'b0);

    // Positive overflow then recovery
    smp = '{8'd100, 8'd100, 8'hCE, 8'hCE};
    run_frame(smp, 1'b1, 1'b0);

    // Backpressure: result must stay put while out_ready is low
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    smp = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    run_frame(smp, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", 32'(out_data), 32'(last_exp.data));
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Clear mid-frame with a simultaneous offered sample
    send(8'h03);
    send(8'h22);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h7F;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("clear_in_ready", 32'(in_ready), 32'd1);
    check("clear_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    smp = '{8'd1, 8'd1, 8'd1, 8'd1};
    run_frame(smp, 1'b1, 1'b0);

    // Reset while holding a result discards it
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    smp = '{8'h40, 8'h11, 8'hF0, 8'h02};
    run_frame(smp, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("hold_rst_valid", 32'(out_valid), 32'd0);
    check("hold_rst_data", 32'(out_data), 32'd0);
    check("hold_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    smp = '{8'h10, 8'h20, 8'hE0, 8'h05};
    run_frame(smp, 1'b1, 1'b0);

    // Single-sample frames on the N=1 instance
    @(posedge clk);
    #1;
    in_data1  = 8'h80;
    in_valid1 = 1'b1;
    @(negedge clk);
    check("n1_in_ready", 32'(in_ready1), 32'd1);
    check("n1_idle_valid", 32'(out_valid1), 32'd0);
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    @(negedge clk);
    check("n1_valid", 32'(out_valid1), 32'd1);
    check("n1_data", 32'(out_data1), 32'h0F80);
    check("n1_ovf", 32'(out_ovf1), 32'd0);
    check("n1_hold_in_ready", 32'(in_ready1), 32'd0);
    @(posedge clk);
    #1;
    out_ready1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("n1_done_valid", 32'(out_valid1), 32'd0);

    // Randomized frames with gaps and random downstream readiness
    @(posedge clk);
    #1;
    rand_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < N; i++) smp[i] = 8'($urandom);
      run_frame(smp, 1'b1, 1'b1);
    end

    // Drain
    @(posedge clk);
    #1;
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    guard      = 0;
    while (sb.size() != 0 && guard < 50) begin
      @(posedge clk);
      guard++;
    end
    @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
